// File: rtl/mux_8_to_1.sv
// mux_8_to_1: registered 8-to-1 lane multiplexer.
// Picks lane s (WIDTH bits) from the packed bus d and registers it on o;
// out_valid flags the cycle after a capture.
// Build option: define MUX_8_TO_1_BYPASS_EN to make o/out_valid purely
// combinational (o = en ? lane : 0, out_valid = en); clk/rst_n then go unused.

// One output bit: picks bit y out of the eight lanes' same-position bits.
module mux_8_to_1_bit (
  input  logic [7:0] v,
  input  logic [2:0] s,
  output logic       y
);

  // Full case over all select codes; default keeps y driven if s is unknown.
  always_comb begin
    y = 1'b0;
    case (s)
      3'd0:    y = v[0];
      3'd1:    y = v[1];
      3'd2:    y = v[2];
      3'd3:    y = v[3];
      3'd4:    y = v[4];
      3'd5:    y = v[5];
      3'd6:    y = v[6];
      3'd7:    y = v[7];
      default: y = 1'b0;
    endcase
  end

endmodule

module mux_8_to_1 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [8*WIDTH-1:0] d,
  input  logic [2:0]         s,
  input  logic               en,
  output logic [WIDTH-1:0]   o,
  output logic               out_valid
);

  localparam int NUM_LANES = 8;
  localparam int STAGES    = 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             vld;
  } rsp_t;

  // Lane k sits at d[k*WIDTH +: WIDTH]; the packed view makes that lanes[k].
  logic [NUM_LANES-1:0][WIDTH-1:0] lanes;
  logic [WIDTH-1:0]                sel_data;

  assign lanes = d;

  // One bit-slice mux per output bit, each fed by that bit of every lane.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [NUM_LANES-1:0] col;
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_col
      assign col[k] = lanes[k][b];
    end
    mux_8_to_1_bit u_bit (
      .v (col),
      .s (s),
      .y (sel_data[b])
    );
  end

`ifdef MUX_8_TO_1_BYPASS_EN

  // Zero-latency path: output follows the select while en is high.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;
  assign o              = en ? sel_data : '0;
  assign out_valid      = en;

`else

  logic [STAGES:0]  vld_pipe;
  logic [WIDTH-1:0] data_q;
  rsp_t             rsp;

  assign vld_pipe[0] = en;

  // Valid marks exactly the cycle after a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe[STAGES:1] <= '0;
    else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  // Data register only loads on en, so it holds across idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  data_q <= '0;
    else if (en) data_q <= sel_data;
  end

  assign rsp       = '{data: data_q, vld: vld_pipe[STAGES]};
  assign o         = rsp.data;
  assign out_valid = rsp.vld;

`endif

endmodule

// File: tb/tb_mux_8_to_1.sv
// Testbench for mux_8_to_1: a WIDTH=1 and a WIDTH=8 instance driven with the
// same select/enable/reset. Stimulus pushes expected lanes into queues; a
// negedge monitor pops them whenever out_valid is seen and checks holds.
module tb_mux_8_to_1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  d1;
  logic [63:0] d8;
  logic [2:0]  s;
  logic        en;
  logic        o1;
  logic [7:0]  o8;
  logic        vld1, vld8;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q1[$];
  logic [7:0] q8[$];
  logic [7:0] last1 = '0;
  logic [7:0] last8 = '0;
  logic       exp_vld = 1'b0;

  always #5 clk = ~clk;

  mux_8_to_1 #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .d(d1), .s(s), .en(en), .o(o1), .out_valid(vld1)
  );

  mux_8_to_1 #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .d(d8), .s(s), .en(en), .o(o8), .out_valid(vld8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: lane s of a bus of eight w-bit lanes, by plain shift and mask.
  function automatic logic [7:0] lane(input logic [63:0] bus, input int sel, input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return 8'((bus >> (sel * w)) & mask);
  endfunction

  // Drive one cycle of inputs; the model records what the next edge captures.
  task automatic step(input logic [7:0] a1, input logic [63:0] a8,
                      input logic [2:0] sel, input logic e);
    d1 = a1; d8 = a8; s = sel; en = e;
    @(posedge clk);
    if (e) begin
      q1.push_back(lane({56'd0, a1}, int'(sel), 1));
      q8.push_back(lane(a8, int'(sel), 8));
    end
    exp_vld = e;
    #1;
  endtask

  task automatic model_reset();
    q1.delete(); q8.delete();
    last1 = '0; last8 = '0;
    exp_vld = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_o1"}, {63'd0, o1}, 64'd0);
    chk({tag, "_o8"}, {56'd0, o8}, 64'd0);
    chk({tag, "_v1"}, {63'd0, vld1}, 64'd0);
    chk({tag, "_v8"}, {63'd0, vld8}, 64'd0);
  endtask

  // Monitor: pops an expectation on every valid, otherwise expects a hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_o1", {63'd0, o1}, 64'd0);
      chk("rst_v1", {63'd0, vld1}, 64'd0);
      chk("rst_o8", {56'd0, o8}, 64'd0);
    end else begin
      chk("vld1", {63'd0, vld1}, {63'd0, exp_vld});
      chk("vld8", {63'd0, vld8}, {63'd0, exp_vld});
      if (vld1) begin
        if (q1.size() == 0) chk("q1_empty", 64'd1, 64'd0);
        else begin
          last1 = q1.pop_front();
          chk("o1", {63'd0, o1}, {56'd0, last1});
        end
      end else chk("hold1", {63'd0, o1}, {56'd0, last1});
      if (vld8) begin
        if (q8.size() == 0) chk("q8_empty", 64'd1, 64'd0);
        else begin
          last8 = q8.pop_front();
          chk("o8", {56'd0, o8}, {56'd0, last8});
        end
      end else chk("hold8", {56'd0, o8}, {56'd0, last8});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] WIDE = 64'h7766_5544_3322_1100;

  initial begin
    // Asynchronous reset with capture-worthy inputs: zeros without an edge.
    d1 = 8'hFF; d8 = WIDE; s = 3'd3; en = 1'b1;
    #0 rst_n = 1'b0;
    #2 chk_zero("rst_async");
    @(posedge clk); @(posedge clk); #1;
    chk_zero("rst_hold");
    rst_n = 1'b1;

    // Full sweeps, both polarities.
    for (int i = 0; i < 8; i++) step(8'b0101_0101, WIDE, 3'(i), 1'b1);
    for (int i = 0; i < 8; i++) step(8'b1010_1010, WIDE, 3'(i), 1'b1);

    // Hold: capture lane 0, then change d/s with en low.
    step(8'b0101_0101, WIDE, 3'd0, 1'b1);
    step(8'h00, 64'd0, 3'd1, 1'b0);
    step(8'h00, 64'd0, 3'd6, 1'b0);

    // Wide lanes on the 8-bit instance.
    step(8'h00, WIDE, 3'd5, 1'b1);
    step(8'h00, WIDE, 3'd7, 1'b1);
    step(8'h00, WIDE, 3'd7, 1'b0);

    // Reset pulse mid-sweep, between edges; pending capture is dropped.
    for (int i = 0; i < 5; i++) step(8'b0101_0101, WIDE, 3'(i), 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1 chk_zero("rst_mid");
    #1 rst_n = 1'b1;
    step(8'b0101_0101, WIDE, 3'd2, 1'b1);
    step(8'b0101_0101, WIDE, 3'd2, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++)
      step(8'($urandom), {$urandom, $urandom}, 3'($urandom_range(0, 7)),
           ($urandom_range(0, 9) < 7));
    step(8'h00, 64'd0, 3'd0, 1'b0);
    step(8'h00, 64'd0, 3'd0, 1'b0);

    @(negedge clk); #1;
    chk("drain1", 64'(q1.size()), 64'd0);
    chk("drain8", 64'(q8.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
